// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction fields and memory handshake in, strobes, mux selects and status out.
// The control unit uses the master modport; the datapath/memory side uses slave.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
);
    logic [6:0]            Opcode;
    logic [2:0]            Funct_Tres;
    logic [6:0]            Funct_Siete;
    logic                  MemReady;
    logic                  MemReq;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  PCWrite;
    logic                  RegWrite;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  WDSrc;
    logic                  ImmReg;
    logic                  ALUSrc;
    logic                  MemToReg;
    logic                  IllegalInstr;
    logic                  TimeoutErr;
    logic [CNT_W-1:0]      InstrCount;

    modport master (
        input  Opcode, Funct_Tres, Funct_Siete, MemReady,
        output MemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
               ALUControl, WDSrc, ImmReg, ALUSrc, MemToReg,
               IllegalInstr, TimeoutErr, InstrCount
    );

    modport slave (
        output Opcode, Funct_Tres, Funct_Siete, MemReady,
        input  MemReq, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
               ALUControl, WDSrc, ImmReg, ALUSrc, MemToReg,
               IllegalInstr, TimeoutErr, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing over a shared memory port,
// with illegal-encoding and memory-timeout traps and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_R  = 3'd0,
        K_I  = 3'd1,
        K_LW = 3'd2,
        K_SW = 3'd3,
        K_U  = 3'd4
    } kind_t;

    state_t            r_state, w_next;
    kind_t             r_kind, w_kind;
    logic [2:0]        r_alu, w_alu;
    logic              w_legal;
    logic [WAIT_W-1:0] r_wait, w_wait_next, w_wait_inc;
    logic [CNT_W-1:0]  r_count;
    logic              r_illegal, r_timeout;
    logic              w_retire, w_set_illegal, w_set_timeout;
    logic              w_expired, w_sel_valid;
    logic              w_mem_req, w_mem_read, w_mem_write;
    logic              w_ir_write, w_pc_write, w_reg_write;

    // Instruction classification and ALU operation from the live instruction fields
    always_comb begin
        w_legal = 1'b0;
        w_kind  = K_I;
        w_alu   = 3'b000;
        case (bus.Opcode)
            7'b0110011: begin
                w_kind = K_R;
                case (bus.Funct_Tres)
                    3'b000: begin
                        if (bus.Funct_Siete == 7'b0000000) begin
                            w_legal = 1'b1;
                            w_alu   = 3'b000;
                        end else if (bus.Funct_Siete == 7'b0100000) begin
                            w_legal = 1'b1;
                            w_alu   = 3'b001;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'b111: begin
                        w_legal = (bus.Funct_Siete == 7'b0000000);
                        w_alu   = 3'b010;
                    end
                    3'b100: begin
                        w_legal = (bus.Funct_Siete == 7'b0000000);
                        w_alu   = 3'b011;
                    end
                    3'b001: begin
                        w_legal = (bus.Funct_Siete == 7'b0000000);
                        w_alu   = 3'b100;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_kind  = K_I;
                w_legal = (bus.Funct_Tres == 3'b000);
            end
            7'b0000011: begin
                w_kind  = K_LW;
                w_legal = (bus.Funct_Tres == 3'b010);
            end
            7'b0100011: begin
                w_kind  = K_SW;
                w_legal = (bus.Funct_Tres == 3'b010);
            end
            7'b0110111: begin
                w_kind  = K_U;
                w_legal = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // A wait count equal to the limit still lets a same-cycle MemReady through; only a miss traps.
    assign w_expired  = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LIMIT);
    assign w_wait_inc = (MEM_TIMEOUT == 0) ? '0 : (r_wait + WAIT_ONE);

    // Next-state and strobe decode
    always_comb begin
        w_next        = r_state;
        w_wait_next   = '0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.MemReady) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_TRAP;
                end else begin
                    w_wait_next = w_wait_inc;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if (r_kind == K_LW || r_kind == K_SW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_read  = (r_kind == K_LW);
                w_mem_write = (r_kind == K_SW);
                if (bus.MemReady) begin
                    if (r_kind == K_SW) begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_TRAP;
                end else begin
                    w_wait_next = w_wait_inc;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // State, decode latch, wait counter, retirement counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_kind    <= K_I;
            r_alu     <= 3'b000;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (r_state == S_DECODE) begin
                r_kind <= w_kind;
                r_alu  <= w_alu;
            end
            if (w_retire) begin
                r_count <= r_count + CNT_ONE;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_sel_valid = !rst && (r_state == S_EXECUTE || r_state == S_MEM || r_state == S_WB);

    assign bus.MemReq       = w_mem_req   & ~rst;
    assign bus.MemRead      = w_mem_read  & ~rst;
    assign bus.MemWrite     = w_mem_write & ~rst;
    assign bus.IRWrite      = w_ir_write  & ~rst;
    assign bus.PCWrite      = w_pc_write  & ~rst;
    assign bus.RegWrite     = w_reg_write & ~rst;
    assign bus.ALUControl   = w_sel_valid ? ALU_CTRL_W'(r_alu) : '0;
    assign bus.WDSrc        = w_sel_valid && (r_kind != K_U);
    assign bus.ImmReg       = w_sel_valid && (r_kind == K_SW);
    assign bus.ALUSrc       = w_sel_valid && (r_kind == K_R);
    assign bus.MemToReg     = w_sel_valid && (r_kind == K_LW);
    assign bus.IllegalInstr = r_illegal & ~rst;
    assign bus.TimeoutErr   = r_timeout & ~rst;
    assign bus.InstrCount   = rst ? '0 : r_count;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: dut0 (timeout 16, 32-bit count) and dut1 (timeout disabled, 4-bit count).
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(3), .CNT_W(32)) bus0 ();
    multicycle_control_unit_if #(.ALU_CTRL_W(3), .CNT_W(4))  bus1 ();

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(16), .CNT_W(32)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(0), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    // Output vector layout: {req,rd,wr}_{ir,pc,rw}_{alu}_{wd,imm,src,m2r}_{ill,to}
    localparam logic [14:0] V_IDLE  = 15'b000_000_000_0000_00;
    localparam logic [14:0] V_FETCH = 15'b100_100_000_0000_00;
    localparam logic [14:0] V_FWAIT = 15'b100_000_000_0000_00;
    localparam logic [14:0] V_WB    = 15'b000_011_000_0000_00;
    localparam logic [14:0] V_ILL   = 15'b000_000_000_0000_10;
    localparam logic [14:0] V_TMO   = 15'b000_000_000_0000_01;

    function automatic logic [14:0] sel(input logic [2:0] alu, input logic wd, input logic imm,
                                        input logic src, input logic m2r);
        return {6'b000000, alu, wd, imm, src, m2r, 2'b00};
    endfunction

    function automatic logic [14:0] outs0();
        return {bus0.MemReq, bus0.MemRead, bus0.MemWrite, bus0.IRWrite, bus0.PCWrite,
                bus0.RegWrite, bus0.ALUControl, bus0.WDSrc, bus0.ImmReg, bus0.ALUSrc,
                bus0.MemToReg, bus0.IllegalInstr, bus0.TimeoutErr};
    endfunction

    function automatic logic [14:0] outs1();
        return {bus1.MemReq, bus1.MemRead, bus1.MemWrite, bus1.IRWrite, bus1.PCWrite,
                bus1.RegWrite, bus1.ALUControl, bus1.WDSrc, bus1.ImmReg, bus1.ALUSrc,
                bus1.MemToReg, bus1.IllegalInstr, bus1.TimeoutErr};
    endfunction

    task automatic set0(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus0.Opcode      = op;
        bus0.Funct_Tres  = f3;
        bus0.Funct_Siete = f7;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        rst1 = 1'b1;
        set0(7'b0110011, 3'b000, 7'b0000000);
        bus0.MemReady = 1'b1;
        bus1.Opcode = 7'b0110011; bus1.Funct_Tres = 3'b000; bus1.Funct_Siete = 7'b0000000;
        bus1.MemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {V_IDLE, 32'd0}) begin
                failures++;
                $display("FAIL reset0 cyc%0d got=%b/%0d exp=%b/0", c, outs0(), bus0.InstrCount, V_IDLE);
            end
        end
        checks++;
        if ({outs1(), bus1.InstrCount} !== {V_IDLE, 4'd0}) begin
            failures++;
            $display("FAIL reset1 got=%b/%0d exp=%b/0", outs1(), bus1.InstrCount, V_IDLE);
        end
    endtask

    task automatic test_add();
        logic [14:0] exp [4];
        exp = '{V_FETCH, V_IDLE, sel(3'b000, 1'b1, 1'b0, 1'b1, 1'b0),
                V_WB | sel(3'b000, 1'b1, 1'b0, 1'b1, 1'b0)};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) rst0 = 1'b0;
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp[c], 32'd0}) begin
                failures++;
                $display("FAIL add cyc%0d got=%b/%0d exp=%b/0", c, outs0(), bus0.InstrCount, exp[c]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  f3s  [3];
        logic [6:0]  f7s  [3];
        logic [2:0]  alus [3];
        logic [14:0] exp  [4];
        f3s  = '{3'b000, 3'b001, 3'b100};
        f7s  = '{7'b0100000, 7'b0000000, 7'b0000000};
        alus = '{3'b001, 3'b100, 3'b011};
        for (int k = 0; k < 3; k++) begin
            exp = '{V_FETCH, V_IDLE, sel(alus[k], 1'b1, 1'b0, 1'b1, 1'b0),
                    V_WB | sel(alus[k], 1'b1, 1'b0, 1'b1, 1'b0)};
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) set0(7'b0110011, f3s[k], f7s[k]);
                #1;
                checks++;
                if ({outs0(), bus0.InstrCount} !== {exp[c], 32'(k + 1)}) begin
                    failures++;
                    $display("FAIL alu_op%0d cyc%0d got=%b/%0d exp=%b/%0d", k, c, outs0(),
                             bus0.InstrCount, exp[c], k + 1);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] s_lw;
        logic [14:0] exp [8];
        logic        rdy [8];
        s_lw = sel(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        exp  = '{V_FETCH, V_IDLE, s_lw, 15'b110_000_000_0000_00 | s_lw, 15'b110_000_000_0000_00 | s_lw,
                 15'b110_000_000_0000_00 | s_lw, 15'b110_000_000_0000_00 | s_lw, V_WB | s_lw};
        rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) set0(7'b0000011, 3'b010, 7'b0000000);
            if (c == 2) set0(7'b1111111, 3'b111, 7'b1111111);
            bus0.MemReady = rdy[c];
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp[c], 32'd4}) begin
                failures++;
                $display("FAIL lw_wait cyc%0d got=%b/%0d exp=%b/4", c, outs0(), bus0.InstrCount, exp[c]);
            end
        end
    endtask

    task automatic test_sw();
        logic [14:0] s_sw;
        logic [14:0] exp [4];
        s_sw = sel(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        exp  = '{V_FETCH, V_IDLE, s_sw, 15'b101_010_000_0000_00 | s_sw};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) set0(7'b0100011, 3'b010, 7'b0000000);
            bus0.MemReady = 1'b1;
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp[c], 32'd5}) begin
                failures++;
                $display("FAIL sw cyc%0d got=%b/%0d exp=%b/5", c, outs0(), bus0.InstrCount, exp[c]);
            end
        end
    endtask

    task automatic test_imm_upper();
        logic [6:0]  ops  [2];
        logic [14:0] sels [2];
        logic [14:0] exp  [4];
        ops  = '{7'b0110111, 7'b0010011};
        sels = '{sel(3'b000, 1'b0, 1'b0, 1'b0, 1'b0), sel(3'b000, 1'b1, 1'b0, 1'b0, 1'b0)};
        for (int k = 0; k < 2; k++) begin
            exp = '{V_FETCH, V_IDLE, sels[k], V_WB | sels[k]};
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) set0(ops[k], (k == 0) ? 3'b101 : 3'b000, (k == 0) ? 7'b1010101 : 7'b0000000);
                #1;
                checks++;
                if ({outs0(), bus0.InstrCount} !== {exp[c], 32'(6 + k)}) begin
                    failures++;
                    $display("FAIL imm_upper%0d cyc%0d got=%b/%0d exp=%b/%0d", k, c, outs0(),
                             bus0.InstrCount, exp[c], 6 + k);
                end
            end
        end
    endtask

    task automatic test_timeout_boundary();
        logic [14:0] exp;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c == 0) set0(7'b0110011, 3'b001, 7'b0100000);
            bus0.MemReady = (c == 16);
            exp = (c == 16) ? V_FETCH : V_FWAIT;
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp, 32'd8}) begin
                failures++;
                $display("FAIL timeout_boundary cyc%0d got=%b/%0d exp=%b/8", c, outs0(), bus0.InstrCount, exp);
            end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp [3];
        exp = '{V_IDLE, V_ILL, V_ILL};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus0.MemReady = 1'b1;
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp[c], 32'd8}) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%b/%0d exp=%b/8", c, outs0(), bus0.InstrCount, exp[c]);
            end
        end
    endtask

    task automatic test_timeout_trap();
        logic [14:0] exp;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rst0 = (c == 0);
            bus0.MemReady = 1'b0;
            exp = (c == 0) ? V_IDLE : ((c <= 17) ? V_FWAIT : V_TMO);
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp, 32'd0}) begin
                failures++;
                $display("FAIL timeout_trap cyc%0d got=%b/%0d exp=%b/0", c, outs0(), bus0.InstrCount, exp);
            end
        end
    endtask

    task automatic test_rst_mid_mem();
        logic [14:0] s_sw;
        logic [14:0] exp [7];
        logic        rdy [7];
        s_sw = sel(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        exp  = '{V_IDLE, V_FETCH, V_IDLE, s_sw, 15'b101_000_000_0000_00 | s_sw, V_IDLE, V_FWAIT};
        rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            rst0 = (c == 0 || c == 5);
            if (c == 0) set0(7'b0100011, 3'b010, 7'b0000000);
            bus0.MemReady = rdy[c];
            #1;
            checks++;
            if ({outs0(), bus0.InstrCount} !== {exp[c], 32'd0}) begin
                failures++;
                $display("FAIL rst_mid_mem cyc%0d got=%b/%0d exp=%b/0", c, outs0(), bus0.InstrCount, exp[c]);
            end
        end
    endtask

    task automatic test_no_timeout();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst1 = 1'b0;
            bus1.MemReady = 1'b0;
            #1;
            checks++;
            if ({outs1(), bus1.InstrCount} !== {V_FWAIT, 4'd0}) begin
                failures++;
                $display("FAIL no_timeout cyc%0d got=%b/%0d exp=%b/0", c, outs1(), bus1.InstrCount, V_FWAIT);
            end
        end
    endtask

    task automatic test_count_wrap();
        for (int c = 0; c <= 68; c++) begin
            @(negedge clk);
            bus1.MemReady = 1'b1;
            #1;
            if (c % 4 == 0) begin
                checks++;
                if ({bus1.MemReq, bus1.IRWrite, bus1.InstrCount} !== {2'b11, 4'((c / 4) % 16)}) begin
                    failures++;
                    $display("FAIL count_wrap instr%0d got=%b%b/%0d exp=11/%0d", c / 4, bus1.MemReq,
                             bus1.IRWrite, bus1.InstrCount, (c / 4) % 16);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_wait();
        test_sw();
        test_imm_upper();
        test_timeout_boundary();
        test_illegal();
        test_timeout_trap();
        test_rst_mid_mem();
        test_no_timeout();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
